// File: rtl/pmod_ja_arbiter.sv
// pmod_ja_arbiter: round-robin owner of the 8-pin PMOD JA port with an all-OE-low turnaround between owners.
// Optional forced release after MAX_HOLD owned cycles when PMOD_ARB_TIMEOUT_EN is defined.
module pmod_ja_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 1024
) (
  input  logic                 clk_ext,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ*8-1:0] req_dout,
  input  logic [NUM_REQ*8-1:0] req_oe,
  input  logic [7:0]           pmod_din,
  output logic [7:0]           rd_data,
  output logic [7:0]           pmod_dout,
  output logic [7:0]           pmod_oe,
  output logic                 busy,
  output logic                 timeout_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = TURN_CYC > 0 ? $clog2(TURN_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;
  state_t state, nxt;
  logic [IW-1:0] w, last, pick, nxt_w;
  logic [TW-1:0] turn_cnt;
  logic [NUM_REQ-1:0] others, cand;
  logic [7:0] sync0;
  logic found, rel, force_rel, enter_own, drive;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TURN_CYC < 0 || TURN_CYC > 15 || MAX_HOLD < 1) begin : g_bad_param
    $error("pmod_ja_arbiter: parameter out of range");
  end
  assign others = req & ~(NUM_REQ'(1) << w);
  // a releasing owner only competes again when nobody else is asking
  assign cand = (state == OWN && others != '0) ? others : req;
  assign rel = state == OWN && (!req[w] || force_rel);
  assign enter_own = nxt == OWN && (state != OWN || rel);
  assign drive = state == OWN && !rel;
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = (int'(last) + i) % NUM_REQ;
      if (!found && cand[k]) begin
        pick = IW'(k);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    nxt_w = w;
    if (state == IDLE && found) begin
      nxt_w = pick;
      nxt = (TURN_CYC == 0) ? OWN : TURN;
    end else if (state == TURN) begin
      nxt = !req[w] ? IDLE : (turn_cnt == TW'(TURN_CYC - 1)) ? OWN : TURN;
    end else if (rel) begin
      nxt_w = pick;
      nxt = !found ? IDLE : (TURN_CYC == 0) ? OWN : TURN;
    end
  end
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      last <= IW'(NUM_REQ - 1);
      turn_cnt <= '0;
      grant <= '0;
      pmod_dout <= '0;
      pmod_oe <= '0;
      busy <= 1'b0;
      sync0 <= '0;
      rd_data <= '0;
    end else begin
      state <= nxt;
      w <= nxt_w;
      if (enter_own) last <= nxt_w;
      turn_cnt <= (state == TURN && nxt == TURN) ? turn_cnt + 1'b1 : '0;
      grant <= (nxt == OWN) ? NUM_REQ'(1) << nxt_w : '0;
      pmod_oe <= drive ? req_oe[w*8 +: 8] : '0;
      if (drive) pmod_dout <= req_dout[w*8 +: 8];
      busy <= nxt != IDLE;
      sync0 <= pmod_din;
      rd_data <= sync0;
    end
  end
`ifdef PMOD_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold;
  assign force_rel = state == OWN && hold == HW'(MAX_HOLD) && others != '0;
  // counts owned cycles including the entry cycle; saturates instead of wrapping
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      hold <= enter_own ? HW'(1) : (state == OWN && hold != HW'(MAX_HOLD)) ? hold + 1'b1 : hold;
      timeout_pulse <= force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
endmodule
